// File: rtl/lif_param_loader.sv
// Serial configuration loader for the LIF neuron array: stages NUM_WEIGHTS+3 fields and commits them atomically.
// Optional build macro LOADER_CHECKSUM_EN appends an XOR checksum field that gates the commit.
module lif_param_loader #(
   parameter int unsigned NUM_WEIGHTS         = 2,
   parameter int unsigned W_WIDTH             = 3,
   parameter int unsigned DATA_W              = 8,
   parameter int unsigned LC_W                = 4,
   parameter int unsigned DEFAULT_W           = 2,
   parameter int unsigned DEFAULT_LEAK_RATE   = 2,
   parameter int unsigned DEFAULT_THR_MIN     = 30,
   parameter int unsigned DEFAULT_LEAK_CYCLES = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            serial_data_in,
   input  logic                            load_enable,
   output logic [NUM_WEIGHTS*W_WIDTH-1:0]  weights,
   output logic [DATA_W-1:0]               leak_rate,
   output logic [DATA_W-1:0]               threshold_min,
   output logic [LC_W-1:0]                 leak_cycles,
   output logic                            params_ready,
   output logic                            commit_pulse,
   output logic                            load_error
);

   localparam int unsigned NF     = NUM_WEIGHTS + 3;
`ifdef LOADER_CHECKSUM_EN
   localparam int unsigned NF_TOT = NF + 1;
`else
   localparam int unsigned NF_TOT = NF;
`endif
   // The last field is consumed straight from the shifter, so it needs no shadow slot.
   localparam int unsigned SH_N   = NF_TOT - 1;
   localparam int unsigned BC_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned FI_W   = $clog2(NF_TOT);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [BC_W-1:0]   bit_cnt;
   logic [FI_W-1:0]   field_idx;
   logic [DATA_W-2:0] sr;
   logic [DATA_W-1:0] shadow [SH_N];

   logic              start_c, shift_c, abort_c, word_done_c, last_c, csum_ok_c;
   logic [DATA_W-1:0] word_c;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; nothing moves while enable is low
   always_comb begin
      state_d = state_q;
      if (enable) begin
         case (state_q)
            ST_IDLE:  if (load_enable) state_d = ST_SHIFT;
            ST_SHIFT: begin
               if (!load_enable) state_d = ST_IDLE;
               else if (last_c)  state_d = ST_DONE;
            end
            ST_DONE:  if (!load_enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Control strobes decoded from state and inputs
   always_comb begin
      start_c     = enable && (state_q == ST_IDLE)  && load_enable;
      shift_c     = enable && (state_q == ST_SHIFT) && load_enable;
      abort_c     = enable && (state_q == ST_SHIFT) && !load_enable;
      word_c      = {sr, serial_data_in};
      word_done_c = shift_c && (bit_cnt == BC_W'(DATA_W - 1));
      last_c      = word_done_c && (field_idx == FI_W'(NF_TOT - 1));
   end

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] csum_c;

   always_comb begin
      csum_c = '0;
      for (int unsigned i = 0; i < SH_N; i++) csum_c = csum_c ^ shadow[i];
      csum_ok_c = (csum_c == word_c);
   end
`else
   logic unused_c;

   // Raw bits above each field's kept width are intentionally dropped
   always_comb begin
      csum_ok_c = 1'b1;
      unused_c  = ^word_c;
      for (int unsigned i = 0; i < SH_N; i++) unused_c = unused_c ^ (^shadow[i]);
   end
`endif

   // Datapath: shifter, shadow staging, atomic commit and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt       <= '0;
         field_idx     <= '0;
         sr            <= '0;
         for (int unsigned i = 0; i < SH_N; i++) shadow[i] <= '0;
         weights       <= {NUM_WEIGHTS{W_WIDTH'(DEFAULT_W)}};
         leak_rate     <= DATA_W'(DEFAULT_LEAK_RATE);
         threshold_min <= DATA_W'(DEFAULT_THR_MIN);
         leak_cycles   <= LC_W'(DEFAULT_LEAK_CYCLES);
         params_ready  <= 1'b1;
         commit_pulse  <= 1'b0;
         load_error    <= 1'b0;
      end else begin
         commit_pulse <= 1'b0;
         if (start_c) begin
            bit_cnt      <= '0;
            field_idx    <= '0;
            params_ready <= 1'b0;
            load_error   <= 1'b0;
         end
         if (shift_c) begin
            sr      <= word_c[DATA_W-2:0];
            bit_cnt <= bit_cnt + BC_W'(1);
            if (word_done_c) begin
               bit_cnt   <= '0;
               field_idx <= field_idx + FI_W'(1);
               for (int unsigned i = 0; i < SH_N; i++)
                  if (field_idx == FI_W'(i)) shadow[i] <= word_c;
            end
            if (last_c) begin
               params_ready <= 1'b1;
               if (csum_ok_c) begin
                  for (int unsigned k = 0; k < NUM_WEIGHTS; k++)
                     weights[k*W_WIDTH +: W_WIDTH] <= shadow[k][W_WIDTH-1:0];
                  leak_rate     <= shadow[NUM_WEIGHTS];
                  threshold_min <= shadow[NUM_WEIGHTS+1];
`ifdef LOADER_CHECKSUM_EN
                  leak_cycles   <= shadow[NUM_WEIGHTS+2][LC_W-1:0];
`else
                  leak_cycles   <= word_c[LC_W-1:0];
`endif
                  commit_pulse  <= 1'b1;
               end else begin
                  load_error    <= 1'b1;
               end
            end
         end
         if (abort_c) begin
            params_ready <= 1'b1;
            load_error   <= 1'b1;
         end
      end
   end

endmodule
